// File: rtl/beehive_vr_pkg.sv
// rtl/beehive_vr_pkg.sv - shared VR replica types and commit-engine controller states
package beehive_vr_pkg;

    localparam int LOG_DEPTH_W   = 6;
    localparam int LINE_BYTES    = 64;
    localparam int VIEW_W        = 32;
    localparam int OPNUM_W       = 64;
    localparam int ENTRY_LEN_W   = 16;

    typedef enum logic [1:0] {
        LOG_ENTRY_FREE      = 2'd0,
        LOG_ENTRY_PREPARED  = 2'd1,
        LOG_ENTRY_COMMITTED = 2'd2
    } log_entry_state_e;

    typedef struct packed {
        log_entry_state_e       entry_state;
        logic [VIEW_W-1:0]      view;
        logic [OPNUM_W-1:0]     op_num;
        logic [ENTRY_LEN_W-1:0] entry_len;
    } log_entry_hdr;

    typedef struct packed {
        logic [VIEW_W-1:0]      view;
        logic [OPNUM_W-1:0]     last_commit;
        logic [OPNUM_W-1:0]     last_op;
        logic [LOG_DEPTH_W-1:0] log_head;
    } vr_state;

    typedef struct packed {
        logic [VIEW_W-1:0]      view;
        logic [OPNUM_W-1:0]     opnum;
    } commit_msg_hdr;

    typedef enum logic [2:0] {
        READY       = 3'd0,
        ST_RD_REQ   = 3'd1,
        ST_RD_RESP  = 3'd2,
        CHECK       = 3'd3,
        LOG_RD_REQ  = 3'd4,
        LOG_RD_RESP = 3'd5,
        LOG_WR      = 3'd6,
        ST_WR       = 3'd7
    } commit_ctrl_state_e;

    // Number of bus lines a log entry of len bytes occupies (at least one).
    function automatic logic [LOG_DEPTH_W-1:0] entry_lines(input logic [ENTRY_LEN_W-1:0] len);
        logic [ENTRY_LEN_W:0] lines;
        lines = ({1'b0, len} + (ENTRY_LEN_W+1)'(LINE_BYTES - 1)) / (ENTRY_LEN_W+1)'(LINE_BYTES);
        if (lines == '0) begin
            lines = (ENTRY_LEN_W+1)'(1);
        end
        return lines[LOG_DEPTH_W-1:0];
    endfunction

endpackage

// File: rtl/commit_eng_ctrl.sv
// rtl/commit_eng_ctrl.sv - sequences one VR COMMIT: state read, check, log walk, state write
module commit_eng_ctrl
    import beehive_vr_pkg::*;
#(
    parameter int MAX_WALK   = 256,
    parameter int MAX_WALK_W = $clog2(MAX_WALK) + 1
) (
    input  logic clk,
    input  logic rst_n,

    input  logic manage_commit_req_val,
    output logic commit_manage_req_rdy,

    output logic commit_vr_state_rd_req_val,
    input  logic vr_state_commit_rd_req_rdy,
    input  logic vr_state_commit_rd_resp_val,
    output logic commit_vr_state_rd_resp_rdy,
    output logic commit_vr_state_wr_req_val,
    input  logic vr_state_commit_wr_req_rdy,

    output logic commit_log_mem_rd_req_val,
    input  logic log_mem_commit_rd_req_rdy,
    input  logic log_mem_commit_rd_resp_val,
    output logic commit_log_mem_rd_resp_rdy,
    output logic commit_log_mem_wr_val,
    input  logic log_mem_commit_wr_rdy,

    output logic ctrl_datap_store_msg,
    output logic ctrl_datap_store_state,
    output logic ctrl_datap_store_log_entry,
    output logic ctrl_datap_calc_next_entry,
    input  logic datap_ctrl_commit_ok,
    input  logic datap_ctrl_last_commit,

    output logic commit_done,
    output logic commit_done_applied,
    output logic commit_walk_err
);

    localparam logic [MAX_WALK_W-1:0] WALK_LIMIT = MAX_WALK_W'(MAX_WALK);

    commit_ctrl_state_e      state_q, state_d;
    logic [MAX_WALK_W-1:0]   walk_cnt_q;
    logic [MAX_WALK_W-1:0]   walk_cnt_nxt;
    logic                    walk_err_q;
    logic                    walk_cnt_clr;
    logic                    walk_cnt_inc;
    logic                    walk_err_set;

    assign walk_cnt_nxt = walk_cnt_q + MAX_WALK_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= READY;
            walk_cnt_q <= '0;
            walk_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (walk_cnt_clr) begin
                walk_cnt_q <= '0;
            end else if (walk_cnt_inc) begin
                walk_cnt_q <= walk_cnt_nxt;
            end
            if (walk_err_set) begin
                walk_err_q <= 1'b1;
            end
        end
    end

    // Sticky flag is masked during reset so every output reads 0 there.
    assign commit_walk_err = walk_err_q & rst_n;

    always_comb begin
        state_d                     = state_q;
        commit_manage_req_rdy       = 1'b0;
        commit_vr_state_rd_req_val  = 1'b0;
        commit_vr_state_rd_resp_rdy = 1'b0;
        commit_vr_state_wr_req_val  = 1'b0;
        commit_log_mem_rd_req_val   = 1'b0;
        commit_log_mem_rd_resp_rdy  = 1'b0;
        commit_log_mem_wr_val       = 1'b0;
        ctrl_datap_store_msg        = 1'b0;
        ctrl_datap_store_state      = 1'b0;
        ctrl_datap_store_log_entry  = 1'b0;
        ctrl_datap_calc_next_entry  = 1'b0;
        commit_done                 = 1'b0;
        commit_done_applied         = 1'b0;
        walk_cnt_clr                = 1'b0;
        walk_cnt_inc                = 1'b0;
        walk_err_set                = 1'b0;

        if (rst_n) begin
            case (state_q)
                READY: begin
                    commit_manage_req_rdy = 1'b1;
                    if (manage_commit_req_val) begin
                        ctrl_datap_store_msg = 1'b1;
                        state_d              = ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    commit_vr_state_rd_req_val = 1'b1;
                    if (vr_state_commit_rd_req_rdy) begin
                        state_d = ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    commit_vr_state_rd_resp_rdy = 1'b1;
                    if (vr_state_commit_rd_resp_val) begin
                        ctrl_datap_store_state = 1'b1;
                        state_d                = CHECK;
                    end
                end
                CHECK: begin
                    // Datapath registers were loaded last cycle; the verdict is final here.
                    if (datap_ctrl_commit_ok) begin
                        walk_cnt_clr = 1'b1;
                        state_d      = LOG_RD_REQ;
                    end else begin
                        commit_done = 1'b1;
                        state_d     = READY;
                    end
                end
                LOG_RD_REQ: begin
                    commit_log_mem_rd_req_val = 1'b1;
                    if (log_mem_commit_rd_req_rdy) begin
                        state_d = LOG_RD_RESP;
                    end
                end
                LOG_RD_RESP: begin
                    commit_log_mem_rd_resp_rdy = 1'b1;
                    if (log_mem_commit_rd_resp_val) begin
                        ctrl_datap_store_log_entry = 1'b1;
                        state_d                    = LOG_WR;
                    end
                end
                LOG_WR: begin
                    commit_log_mem_wr_val = 1'b1;
                    if (log_mem_commit_wr_rdy) begin
                        walk_cnt_inc = 1'b1;
                        if (datap_ctrl_last_commit) begin
                            // Address stays on the final entry so it becomes the new log_head.
                            state_d = ST_WR;
                        end else if (walk_cnt_nxt == WALK_LIMIT) begin
                            walk_err_set = 1'b1;
                            commit_done  = 1'b1;
                            state_d      = READY;
                        end else begin
                            ctrl_datap_calc_next_entry = 1'b1;
                            state_d                    = LOG_RD_REQ;
                        end
                    end
                end
                ST_WR: begin
                    commit_vr_state_wr_req_val = 1'b1;
                    if (vr_state_commit_wr_req_rdy) begin
                        commit_done         = 1'b1;
                        commit_done_applied = 1'b1;
                        state_d             = READY;
                    end
                end
                default: begin
                    state_d = READY;
                end
            endcase
        end
    end

endmodule

// File: doc/commit_eng_ctrl.md
Name: commit_eng_ctrl

Overview:
FSM that sequences the commit-engine datapath for one VR COMMIT message. It accepts the message header, reads the replica VR state, and checks view and opnum. If the commit is legal, it walks the log from log_head, marking each entry COMMITTED, until it reaches the entry whose op_num equals the commit opnum. It then writes the updated VR state back. It sits between the manage/dispatch stage, the VR state store, the log memory, and the commit datapath.

Parameters:
MAX_WALK, 256, max log entries marked per commit before abort; must be >= 1.
MAX_WALK_W, $clog2(MAX_WALK)+1, width of the walk counter.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
manage_commit_req_val  in  1  commit header line valid
commit_manage_req_rdy  out  1  header accepted
commit_vr_state_rd_req_val  out  1  VR state read request
vr_state_commit_rd_req_rdy  in  1  state read request accepted
vr_state_commit_rd_resp_val  in  1  state read data valid
commit_vr_state_rd_resp_rdy  out  1  state read data consumed
commit_vr_state_wr_req_val  out  1  state write (data driven by datapath)
vr_state_commit_wr_req_rdy  in  1  state write accepted
commit_log_mem_rd_req_val  out  1  log line read request (addr driven by datapath)
log_mem_commit_rd_req_rdy  in  1  log read request accepted
log_mem_commit_rd_resp_val  in  1  log read data valid
commit_log_mem_rd_resp_rdy  out  1  log read data consumed
commit_log_mem_wr_val  out  1  log line write (addr/data driven by datapath)
log_mem_commit_wr_rdy  in  1  log write accepted
ctrl_datap_store_msg  out  1  latch header
ctrl_datap_store_state  out  1  latch VR state and log_head
ctrl_datap_store_log_entry  out  1  latch log header line
ctrl_datap_calc_next_entry  out  1  advance log address
datap_ctrl_commit_ok  in  1  view/opnum check passed
datap_ctrl_last_commit  in  1  latched entry op_num == commit opnum
commit_done  out  1  one-cycle pulse per message retired
commit_done_applied  out  1  qualifies commit_done: 1 = state written, 0 = dropped
commit_walk_err  out  1  sticky walk-overflow flag; cleared only by reset

Behaviour:
- All outputs are 0 in reset, except commit_manage_req_rdy, which is 1 in READY after reset.
- The FSM returns to READY on any cycle with rst_n=0. A mid-walk reset abandons the walk with no further writes, and the walk counter clears.
- All handshakes fire on val&&rdy. Valids stay asserted until accepted and do not depend on the partner's rdy.

States and transitions:
- READY: rdy=1. On manage_commit_req_val, pulse store_msg and go to ST_RD_REQ.
- ST_RD_REQ: assert state rd_req_val; on accept go to ST_RD_RESP.
- ST_RD_RESP: resp_rdy=1. On resp_val, pulse store_state and go to CHECK. A response arriving in the same cycle as request accept is not legal.
- CHECK (one cycle, datapath regs now valid):
  - !commit_ok: done=1, applied=0, go to READY. No log or state write occurs.
  - commit_ok: clear the walk counter and go to LOG_RD_REQ.
- LOG_RD_REQ: assert rd_req_val; on accept go to LOG_RD_RESP.
- LOG_RD_RESP: resp_rdy=1. On resp_val, pulse store_log_entry and go to LOG_WR.
- LOG_WR: assert wr_val. On accept, increment the walk counter, then:
  - last_commit=1: go to ST_WR.
  - Else, if counter+1 == MAX_WALK: set walk_err, done=1, applied=0, go to READY with no state write.
  - Otherwise: pulse calc_next_entry and go to LOG_RD_REQ.
- ST_WR: assert state wr_req_val. On accept, done=1, applied=1, go to READY. The written log_head equals the address of the final committed entry (calc_next is not pulsed).

Boundary rules:
- A header presented while not READY is back-pressured (rdy=0).
- Log address wrap is modulo 2^LOG_DEPTH_W, handled in the datapath.
- Store pulses are exactly one cycle and mutually exclusive.
- calc_next_entry never coincides with store_state.
- Minimum legal-commit latency with all rdy=1 and 1-cycle reads: 7 + 3*(entries-1) cycles from header accept to done.

Decomposition:
- Add the state enum commit_ctrl_state_e to beehive_vr_pkg.
- Reuse the existing log_entry_hdr, vr_state and commit_msg_hdr types.
- No sub-module. A top commit_eng wrapper instantiates commit_eng_ctrl and commit_eng_datap and connects the ctrl_datap_*/datap_ctrl_* signals.

Test Plan:
- Bad view: state view=3, msg view=2 -> done=1, applied=0; zero log_mem writes and zero state writes.
- Stale opnum: last_commit=5, msg opnum=5 -> dropped, applied=0, no writes.
- Single-entry commit: last_commit=4, last_op=5, opnum=5, log_head=10 -> one wr at addr 10 with state COMMITTED; state written last_commit=5, log_head=10; applied=1.
- Three-entry walk with entry_len=80B on a 512b bus (2 lines each): log_head=0 -> writes at 0, 2, 4; final log_head=4.
- Backpressure: randomly deassert every rdy and delay resp_val up to 5 cycles -> identical write sequence; valids held stable; header rdy=0 while busy.
- MAX_WALK=4 with no matching op_num -> 4 log writes, walk_err=1, applied=0, no state write; reset mid-walk -> READY and walk_err cleared.
